nubus_master_ctrl: RTL

Master-side sequencer for the card's NuBus interface. It accepts single-word or single-byte requests from the local processor bus, arbitrates for NuBus, runs one address/data transaction through `nubus_driver` (`mst_*` inputs), and returns data and status. It retries automatically on try-again-later and aborts on its own watchdog. It sits beside `nubus_slave` inside `nubus` and replaces the tied-off `mst_*` constants there.

---
 rtl/nubus_master_ctrl_pkg.sv | 39 +++
 rtl/nubus_wdt.sv | 39 +++
 rtl/nubus_master_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/nubus_master_ctrl_pkg.sv
// Shared NuBus master definitions: sequencer states, ACK status codes, strobe helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package nubus_master_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_ADDR,
        ST_DATA,
        ST_DONE
    } mst_state_e;

    // Status codes as seen on the active-low lines {nub_tm1n, nub_tm0n} during ACK.
    localparam logic [1:0] TMN_COMPLETE      = 2'b11;
    localparam logic [1:0] TMN_ERROR         = 2'b10;
    localparam logic [1:0] TMN_TIMEOUT       = 2'b01;
    localparam logic [1:0] TMN_TRYAGAINLATER = 2'b00;

    // Word read, word write or a single byte write; everything else is rejected.
    function automatic logic strobe_legal(input logic [3:0] strb);
        case (strb)
            4'b0000, 4'b1111,
            4'b0001, 4'b0010, 4'b0100, 4'b1000: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    // Byte lane carried in AD[1:0] of the address cycle; words use lane 0.
    function automatic logic [1:0] strobe_lane(input logic [3:0] strb);
        case (strb)
            4'b0010: return 2'b01;
            4'b0100: return 2'b10;
            4'b1000: return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/nubus_wdt.sv
// Watchdog counter: counts enabled cycles from zero, flags the all-ones count.
// Latency: expire_o is combinational on the registered count (same cycle).
// Backpressure: none; clr_i has priority over en_i.
//
// Ports: clkn_i (inverted clock, falling edge active), rst_ni (async, active-low),
//        clr_i (restart from 0), en_i (count this cycle), expire_o (count at max while enabled).
module nubus_wdt #(
    parameter int W = 8
) (
    input  logic clkn_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(negedge clkn_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && (cnt_q == {W{1'b1}});

endmodule

// File: rtl/nubus_master_ctrl.sv
// NuBus master sequencer: one CPU word/byte request -> arbitrate, address, data, status.
// Latency: 4 cycles minimum from cpu_valid sample to cpu_ready (immediate grant, first-cycle ACK).
// Backpressure: cpu_valid is held until the one-cycle cpu_ready pulse; own slave cycles defer arbitration.
//
// Ports: cpu_* local request/response; arb/grant external arbiter handshake; slv_slave own
//        slave activity; nub_* sampled bus lines; mst_* controls to nubus_driver (active-low
//        cycle strobes, mst_ad/mst_adoe true-polarity AD drive, mst_timeout watchdog pulse).
module nubus_master_ctrl
    import nubus_master_ctrl_pkg::*;
#(
    parameter int WDT_W     = 8,
    parameter int RETRY_MAX = 3
) (
    input  logic        nub_clkn,
    input  logic        nub_resetn,
    input  logic        cpu_valid,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_write,
    output logic        cpu_ready,
    output logic [31:0] cpu_rdata,
    output logic        cpu_error,
    output logic        cpu_tryagain,
    output logic        arb,
    input  logic        grant,
    input  logic        slv_slave,
    input  logic        nub_ackn,
    input  logic        nub_tm1n,
    input  logic        nub_tm0n,
    input  logic [31:0] nub_adn,
    output logic        mst_arbcyn,
    output logic        mst_adrcyn,
    output logic        mst_dtacyn,
    output logic        mst_ownern,
    output logic        mst_lockedn,
    output logic        mst_tm1n,
    output logic        mst_tm0n,
    output logic        mst_timeout,
    output logic [31:0] mst_ad,
    output logic        mst_adoe
);

    localparam int RC_W = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
    localparam logic [RC_W-1:0] RETRY_LIM = RC_W'(RETRY_MAX);

    mst_state_e      state_q, state_d;
    logic [29:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [3:0]      strb_q, strb_d;
    logic [RC_W-1:0] retry_q, retry_d;
    logic            err_q, err_d;
    logic            tryag_q, tryag_d;
    logic [31:0]     rdata_q, rdata_d;

    logic is_write;
    logic is_byte;
    logic wdt_en;
    logic wdt_expire;

    // The two low address bits are replaced by the byte lane in the address cycle.
    logic addr_lo_unused;
    assign addr_lo_unused = ^cpu_addr[1:0];

    assign is_write = (strb_q != 4'b0000);
    assign is_byte  = is_write && (strb_q != 4'b1111);

    // Watchdog runs only while waiting for ACK; any other state restarts it.
    assign wdt_en = (state_q == ST_DATA) && nub_ackn;

    nubus_wdt #(
        .W(WDT_W)
    ) u_wdt (
        .clkn_i  (nub_clkn),
        .rst_ni  (nub_resetn),
        .clr_i   (state_q != ST_DATA),
        .en_i    (wdt_en),
        .expire_o(wdt_expire)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        retry_d = retry_q;
        err_d   = err_q;
        tryag_d = tryag_q;
        rdata_d = rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                // A request arriving with our own slave cycle simply waits.
                if (cpu_valid && !slv_slave) begin
                    addr_d  = cpu_addr[31:2];
                    wdata_d = cpu_wdata;
                    strb_d  = cpu_write;
                    err_d   = 1'b0;
                    tryag_d = 1'b0;
                    if (strobe_legal(cpu_write)) begin
                        state_d = ST_ARB;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_ARB: begin
                // Slave activity pre-empts us; the latched request stays for the next try.
                if (slv_slave) begin
                    state_d = ST_IDLE;
                end else if (grant) begin
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                state_d = ST_DATA;
            end
            ST_DATA: begin
                if (!nub_ackn) begin
                    if (!is_write) begin
                        rdata_d = ~nub_adn;
                    end
                    case ({nub_tm1n, nub_tm0n})
                        TMN_COMPLETE: begin
                            state_d = ST_DONE;
                        end
                        TMN_ERROR, TMN_TIMEOUT: begin
                            err_d   = 1'b1;
                            state_d = ST_DONE;
                        end
                        default: begin
                            if (retry_q < RETRY_LIM) begin
                                retry_d = retry_q + RC_W'(1);
                                state_d = ST_ARB;
                            end else begin
                                tryag_d = 1'b1;
                                state_d = ST_DONE;
                            end
                        end
                    endcase
                end else if (wdt_expire) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                retry_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(negedge nub_clkn or negedge nub_resetn) begin
        if (!nub_resetn) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            retry_q <= '0;
            err_q   <= 1'b0;
            tryag_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            retry_q <= retry_d;
            err_q   <= err_d;
            tryag_q <= tryag_d;
            rdata_q <= rdata_d;
        end
    end

    // Bus controls decode directly from the state register, so an asynchronous
    // reset releases the bus in the same cycle.
    assign arb          = (state_q == ST_ARB);
    assign mst_arbcyn   = (state_q != ST_ARB);
    assign mst_adrcyn   = (state_q != ST_ADDR);
    assign mst_dtacyn   = (state_q != ST_DATA);
    assign mst_ownern   = !((state_q == ST_ADDR) || (state_q == ST_DATA));
    assign mst_lockedn  = 1'b1;
    assign mst_tm1n     = !((state_q == ST_ADDR) && is_write);
    assign mst_tm0n     = !((state_q == ST_ADDR) && is_byte);
    assign mst_timeout  = wdt_expire;

    // AD drive is gated by slv_slave combinationally so the two drivers never overlap.
    assign mst_adoe = ((state_q == ST_ADDR) || ((state_q == ST_DATA) && is_write)) && !slv_slave;

    always_comb begin
        mst_ad = 32'h0;
        if (state_q == ST_ADDR) begin
            mst_ad = {addr_q, strobe_lane(strb_q)};
        end else if ((state_q == ST_DATA) && is_write) begin
            mst_ad = wdata_q;
        end
    end

    assign cpu_ready    = (state_q == ST_DONE);
    assign cpu_error    = (state_q == ST_DONE) && err_q;
    assign cpu_tryagain = (state_q == ST_DONE) && tryag_q;
    assign cpu_rdata    = rdata_q;

endmodule
